// File: rtl/regfile_pkg.sv
// Shared register-file parameters and write-back payload type.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned ZERO_REG   = 0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  // One-hot select of a register in a NUM_REGS-wide vector.
  function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_ADDR_W-1:0] a);
    return NUM_REGS'(1) << a;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-destination scoreboard for long-latency write-backs.
module reg_scoreboard
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_valid,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] chk_addr1,
  input  logic [REG_ADDR_W-1:0] chk_addr2,
  output logic [NUM_REGS-1:0]   pending,
  output logic                  hazard,
  output logic                  err_c
);

  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

  logic                set_hit_c;
  logic                clr_hit_c;
  logic [NUM_REGS-1:0] set_vec_c;
  logic [NUM_REGS-1:0] clr_vec_c;
  logic [NUM_REGS-1:0] pending_nxt_c;

  // Next pending vector: set beats clear on the same register, r0 never pends.
  always_comb begin
    set_hit_c     = set_valid && (set_addr != ZERO_ADDR);
    clr_hit_c     = clr_valid && (clr_addr != ZERO_ADDR);
    set_vec_c     = set_hit_c ? reg_bit(set_addr) : '0;
    clr_vec_c     = clr_hit_c ? reg_bit(clr_addr) : '0;
    pending_nxt_c = ((pending & ~clr_vec_c) | set_vec_c) & ~reg_bit(ZERO_ADDR);
  end

  // Protocol errors: double issue (unless the old write retires this cycle)
  // or a completion for a register nobody is waiting on.
  always_comb begin
    err_c = 1'b0;
    if (set_hit_c && pending[set_addr] && !(clr_hit_c && (clr_addr == set_addr)))
      err_c = 1'b1;
    if (clr_hit_c && !pending[clr_addr])
      err_c = 1'b1;
  end

  // Operand hazard lookup against committed scoreboard state only.
  assign hazard = pending[chk_addr1] | pending[chk_addr2];

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt_c;
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port arbiter: pipeline (A) vs multi-cycle unit (B),
// with B starvation guard and pending-destination scoreboard.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0]     b_data,
  output logic                  b_ready,
  output logic                  a_stall,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_addr,
  input  logic [REG_ADDR_W-1:0] chk_addr1,
  input  logic [REG_ADDR_W-1:0] chk_addr2,
  output logic                  hazard,
  output logic [NUM_REGS-1:0]   pending,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  err
);

  localparam int unsigned CNT_W = 4;
  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

  logic             grant_a_c;
  logic             grant_b_c;
  wb_req_t          wb_c;
  logic             wr_en_c;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] cnt_inc_c;
  logic [CNT_W-1:0] starve_cnt_nxt_c;
  logic             stall_set_c;
  logic             sb_err_c;
  logic             err_set_c;

  // Fixed priority: A always wins; B only when A is idle.
  assign grant_a_c = a_valid;
  assign grant_b_c = b_valid && !a_valid;
  assign b_ready   = grant_b_c && !rst;

  // Select the granted payload for the write port.
  always_comb begin
    wb_c = '0;
    if (grant_a_c) begin
      wb_c.addr = a_addr;
      wb_c.data = a_data;
    end else if (grant_b_c) begin
      wb_c.addr = b_addr;
      wb_c.data = b_data;
    end
    wr_en_c = (grant_a_c || grant_b_c) && (wb_c.addr != ZERO_ADDR);
  end

  // Count consecutive B denials; at the limit, stall A for one cycle.
  always_comb begin
    starve_cnt_nxt_c = '0;
    stall_set_c      = 1'b0;
    cnt_inc_c        = starve_cnt + CNT_W'(1);
    if (b_valid && !grant_b_c) begin
      if (cnt_inc_c == CNT_W'(STARVE_LIMIT)) stall_set_c = 1'b1;
      else                                   starve_cnt_nxt_c = cnt_inc_c;
    end
  end

  assign err_set_c = sb_err_c || (a_valid && a_stall);

  // Write-port, stall, counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      a_stall    <= 1'b0;
      starve_cnt <= '0;
      err        <= 1'b0;
    end else begin
      rf_we      <= wr_en_c;
      if (grant_a_c || grant_b_c) begin
        rf_waddr <= wb_c.addr;
        rf_wdata <= wb_c.data;
      end
      a_stall    <= stall_set_c;
      starve_cnt <= starve_cnt_nxt_c;
      err        <= err || err_set_c;
    end
  end

  reg_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (iss_valid),
    .set_addr  (iss_addr),
    .clr_valid (grant_b_c),
    .clr_addr  (b_addr),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .pending   (pending),
    .hazard    (hazard),
    .err_c     (sb_err_c)
  );

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler for the 32x32 register file's single write port. It arbitrates between the single-cycle pipeline write-back (source A) and the multi-cycle unit write-back (source B, e.g. multiply/divide or load), and drives the register-file write enable, address and data. It also keeps a pending-destination scoreboard for long-latency ops, giving issue logic a hazard check, and it stops B from being starved.

## Interface
- STARVE_LIMIT, 4, consecutive denied cycles of B before A is stalled; legal range 1..15
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  pipeline write-back request; cannot be back-pressured
- a_addr  in  5  A destination register
- a_data  in  32  A write data
- b_valid  in  1  multi-cycle unit write-back request
- b_addr  in  5  B destination register
- b_data  in  32  B write data
- b_ready  out  1  B accepted this cycle (combinational)
- a_stall  out  1  registered; pipeline must present a_valid=0 in any cycle where a_stall=1
- iss_valid  in  1  long-latency op dispatched to unit B this cycle
- iss_addr  in  5  its destination register
- chk_addr1  in  5  source operand 1 to check
- chk_addr2  in  5  source operand 2 to check
- hazard  out  1  either chk address is pending (combinational)
- pending  out  32  scoreboard bit vector, bit n = register n pending
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)
- err  out  1  sticky protocol-error flag

## Operation
- Grant: grant_a = a_valid. grant_b = b_valid & !a_valid. b_ready = grant_b & !rst.
- A always wins a collision. If A asserts a_valid while a_stall=1, that is a protocol violation: A still wins and err is set.
- Granted source is registered onto rf_we/rf_waddr/rf_wdata. A grant to address 0 drives rf_we=0; the B handshake still completes.
- Starvation counter: increments each cycle b_valid & !b_ready. It clears on a B grant or when b_valid=0.
  - When the counter equals STARVE_LIMIT at a clock edge, a_stall is 1 for exactly the next cycle and the counter clears.
- Scoreboard:
  - iss_valid sets pending[iss_addr].
  - A B grant clears pending[b_addr].
  - If both hit the same address in one cycle, the set wins.
  - pending[0] is constantly 0, and issue to r0 is ignored.
  - Issue to an already-pending register sets err; the bit stays 1.
  - A B grant to a non-pending register, other than r0, sets err.
- hazard = pending[chk_addr1] | pending[chk_addr2]. It reflects register state only, with no same-cycle issue forwarding.
- err clears only on rst.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, a_stall=0, pending=0, err=0, starvation counter=0. b_ready=0 while rst=1.
- Latency: a request granted in cycle N appears on rf_we/rf_waddr/rf_wdata in cycle N+1. The register file commits it at the end of N+1.
- b_ready is valid in the same cycle as b_valid. B must hold b_valid, b_addr and b_data stable until b_ready=1.
- Starvation: B denied in cycles 1..STARVE_LIMIT gives a_stall=1 in cycle STARVE_LIMIT+1, and B is granted in that cycle. Worst-case B wait is STARVE_LIMIT+1 cycles.
- rst asserted mid-operation: all state returns to reset values at that edge. In-flight B requests are dropped, and the pending bits are lost.
- Back-to-back grants (A then B, or B then B) produce consecutive rf_we pulses with no bubble.

## Structure
- Shared package regfile_pkg holds REG_ADDR_W=5, DATA_W=32, NUM_REGS=32 and ZERO_REG=0, shared with the register file.
- Sub-module reg_scoreboard holds the pending vector, the set/clear/priority logic, hazard lookup and the scoreboard err sources.
- Top level holds the arbiter, starvation counter, a_stall register and write-port registers.

## Test plan
- Reset, then idle: all outputs 0 and b_ready=0 during rst. After release with no requests, rf_we stays 0.
- A alone: a_valid=1, a_addr=7, a_data=0xDEADBEEF in cycle N -> rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF in N+1. A to r0 -> rf_we=0.
- Collision: A and B (b_addr=3, b_data=0x55) both valid -> A written, b_ready=0. Next cycle A idle -> b_ready=1, r3 written one cycle later.
- Starvation, STARVE_LIMIT=4: a_valid=1 and b_valid=1 continuously -> a_stall=1 in cycle 5. The bench drops a_valid that cycle, b_ready=1 in cycle 5, and the counter restarts.
- Scoreboard: issue r9 -> pending[9]=1, hazard=1 for chk_addr1=9. B completes r9 while issue r9 in the same cycle -> pending[9] stays 1. A later B completion clears it.
- Errors: issue to pending r4 -> err=1. B write to non-pending r12 -> err=1. a_valid while a_stall=1 -> err=1. err is held until rst.
